add_acc_pipe: RTL
=================

# add_acc_pipe

Parametrised two-stage pipelined adder/accumulator with valid/ready handshakes on input and output. It is the next generation of the team's 4-bit `a + b` adder, generalised in operand and accumulator width, with a per-transaction mode select (plain add or running accumulate), overflow reporting and a transaction counter. It sits between a stimulus or producer stage and a downstream consumer that can apply backpressure.

## Interface
Parameters:
- `WIDTH`, 4 — operand width of `in_a` and `in_b`.
- `ACC_W`, 8 — accumulator and result width. Must satisfy `ACC_W >= WIDTH+1`.
- `CNT_W`, 16 — width of the transaction counter.

Ports:
- `clk` input 1 — single clock; all logic is on its rising edge.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `in_valid` input 1 — an input transaction is present.
- `in_ready` output 1 — the block can accept an input transaction.
- `in_a` input WIDTH — operand A, unsigned.
- `in_b` input WIDTH — operand B, unsigned.
- `in_mode` input 1 — 0 = add, 1 = accumulate.
- `acc_clr` input 1 — synchronous accumulator clear.
- `out_valid` output 1 — a result is present.
- `out_ready` input 1 — the consumer accepts the result.
- `out_sum` output ACC_W — the result.
- `out_ovf` output 1 — overflow flag for the result currently presented.
- `op_count` output CNT_W — number of accepted input transactions.

## Operation
- **Accept.** An input is accepted when `in_valid && in_ready`.
- **Pipeline advance.** `adv = !out_valid || out_ready`. `in_ready = adv`. The pipeline is globally stalled while `!adv`.
- **Stage 1** (on accept, when `adv`):
  - Registers `s1_sum = in_a + in_b`, unsigned, WIDTH+1 bits, no truncation.
  - Registers `s1_mode` and `s1_valid`.
  - If `adv` holds but there is no accept, `s1_valid` is loaded with 0 (bubble).
- **Stage 2** (when `adv`): `out_valid <= s1_valid`. When `s1_valid` is set:
  - **Add mode:** `out_sum` = `s1_sum` zero-extended to ACC_W; `out_ovf` = 0; the accumulator is untouched.
  - **Accumulate mode:** `next = acc + s1_sum`, computed at ACC_W+1 bits. `acc` and `out_sum` are loaded with `next[ACC_W-1:0]`. `out_ovf = next[ACC_W]`.
- **`acc_clr`**
  - Sampled every cycle, independent of stall.
  - With no accumulate op completing in that cycle: `acc <= 0`.
  - If an accumulate op completes in the same cycle, the clear applies first: the result is `0 + s1_sum`, with `out_ovf` = 0.
- **`op_count`** increments by 1 on each accept and wraps modulo 2^CNT_W.
- **Stall.** `out_sum`, `out_ovf` and `out_valid` hold stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` low, asynchronous): `out_valid`=0, `out_sum`=0, `out_ovf`=0, `op_count`=0, `acc`=0, `s1_valid`=0.
- `in_ready` is combinational from `out_valid` and `out_ready`. It is 1 during reset deassertion since `out_valid`=0.
- Latency: an input accepted at edge N produces `out_valid`=1 after edge N+1, provided the output was not stalled.
- Throughput: 1 transaction per cycle with `out_ready` held high.
- Reset asserted mid-operation drops in-flight transactions. No partial result is presented after reset release.
- Back-to-back accumulate ops chain correctly; each result includes all prior completed accumulate ops.

## Configuration
- Macro `ADD_ACC_PIPE_SAT_EN`.
- **Defined:** on accumulate overflow (`next[ACC_W]`=1), `acc` and `out_sum` saturate to 2^ACC_W−1 and `out_ovf`=1. Later accumulate ops stay at 2^ACC_W−1, each with `out_ovf`=1.
- **Undefined:** wrap-around as described in Operation, with `out_ovf`=1 on the wrapping result.
- Add mode is unaffected by the macro.

## Test plan
All scenarios use WIDTH=4, ACC_W=8.
- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 immediately; after release `in_ready`=1 and `op_count`=0.
- **Add:** `in_a`=15, `in_b`=15, mode 0, `out_ready`=1 → `out_sum`=30, `out_ovf`=0 one cycle after accept; `op_count`=1.
- **Backpressure:** 3 add ops (1+2, 3+4, 5+6) with `out_ready` low for 4 cycles → `in_ready`=0 once `out_valid`=1; `out_sum`=3 held stable; then 7 and 11 in order, with no loss or duplication.
- **Accumulate wrap** (macro undefined): 9 ops of 15+15, mode 1 → results 30, 60, …, 240, then 14 with `out_ovf`=1 on the 9th.
- **Accumulate saturate** (`ADD_ACC_PIPE_SAT_EN` defined): same stimulus → 9th result 255 with `out_ovf`=1; a 10th op also gives 255 with `out_ovf`=1.
- **Clear collision:** with acc=100, assert `acc_clr` in the cycle an accumulate op with 2+3 completes → `out_sum`=5, `out_ovf`=0; the next accumulate op of 1+1 → 7.

Source files
------------

// File: rtl/add_acc_pipe.sv
// Two-stage pipelined adder/accumulator with valid/ready handshakes, overflow flag and transaction counter.
// Define ADD_ACC_PIPE_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module add_acc_pipe #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  logic             w_adv;
  logic             w_accept;
  logic             w_acc_done;
  logic [WIDTH:0]   w_in_sum;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W:0]   w_acc_next;
  logic [ACC_W-1:0] w_acc_res;
  logic             w_acc_ovf;

  logic [WIDTH:0]   r_s1_sum;
  logic             r_s1_mode;
  logic             r_s1_valid;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_op_count;

  // The whole pipeline moves together; a held result freezes both stages.
  assign w_adv      = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_adv;
  assign w_acc_done = w_adv && r_s1_valid && r_s1_mode;
  assign w_in_sum   = {1'b0, in_a} + {1'b0, in_b};

  // A clear in the completing cycle takes effect before the add.
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_acc_next = {1'b0, w_acc_base} + (ACC_W+1)'(r_s1_sum);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_acc_res = w_acc_next[ACC_W-1:0];
    w_acc_ovf = w_acc_next[ACC_W];
`ifdef ADD_ACC_PIPE_SAT_EN
    if (w_acc_next[ACC_W]) begin
      w_acc_res = '1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sum    <= '0;
      r_s1_mode   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= w_in_sum;
        r_s1_mode <= in_mode;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_mode) begin
          r_out_sum <= w_acc_res;
          r_out_ovf <= w_acc_ovf;
        end else begin
          r_out_sum <= ACC_W'(r_s1_sum);
          r_out_ovf <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_acc_done) begin
      r_acc <= w_acc_res;
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_accept) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign op_count  = r_op_count;

endmodule
